// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg
// Shared definitions for the basic-computer control unit: instruction opcode
// values, common-bus source encodings, ALU operation selects, the bit
// positions of register-reference micro-operations, and the control word
// structure the decoder builds each cycle.
// ---------------------------------------------------------------------------
package bc_pkg;

   // Memory-reference opcodes (IR[14:12]); 7 selects register-reference/IO.
   typedef enum logic [2:0] {
      OP_AND    = 3'd0,
      OP_ADD    = 3'd1,
      OP_LDA    = 3'd2,
      OP_STA    = 3'd3,
      OP_BUN    = 3'd4,
      OP_BSA    = 3'd5,
      OP_ISZ    = 3'd6,
      OP_REG_IO = 3'd7
   } opcode_e;

   // Common-bus source select.
   typedef enum logic [2:0] {
      BUS_NONE = 3'd0,
      BUS_AR   = 3'd1,
      BUS_PC   = 3'd2,
      BUS_DR   = 3'd3,
      BUS_AC   = 3'd4,
      BUS_IR   = 3'd5,
      BUS_TR   = 3'd6,
      BUS_MEM  = 3'd7
   } bus_sel_e;

   // ALU operation select; ALU_PASS (load DR) is the idle value.
   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_AND  = 3'b001,
      ALU_PASS = 3'b010,
      ALU_CMA  = 3'b011,
      ALU_CIR  = 3'b100,
      ALU_CIL  = 3'b101
   } alu_op_e;

   // Register-reference micro-operation bit indices within IR[11:0].
   localparam int RR_CLA = 11;
   localparam int RR_CLE = 10;
   localparam int RR_CMA = 9;
   localparam int RR_CME = 8;
   localparam int RR_CIR = 7;
   localparam int RR_CIL = 6;
   localparam int RR_INC = 5;
   localparam int RR_SPA = 4;
   localparam int RR_SNA = 3;
   localparam int RR_SZA = 2;
   localparam int RR_SZE = 1;
   localparam int RR_HLT = 0;

   // One cycle's worth of control outputs.
   typedef struct packed {
      bus_sel_e bus_sel;
      alu_op_e  alu_opsel;
      logic     ar_ld;
      logic     ar_inc;
      logic     pc_ld;
      logic     pc_inc;
      logic     dr_ld;
      logic     dr_inc;
      logic     ac_ld;
      logic     ac_inc;
      logic     ac_clr;
      logic     ir_ld;
      logic     tr_ld;
      logic     mem_wr;
      logic     e_clr;
      logic     e_cmp;
      logic     e_alu_en;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{bus_sel: BUS_NONE, alu_opsel: ALU_PASS, default: 1'b0};

endpackage

// File: rtl/bc_seq_counter.sv
// ---------------------------------------------------------------------------
// bc_seq_counter
// 3-bit timing-step counter with a one-hot T0..T6 decode.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : return to T0 on the next edge (highest priority)
//   i_hold     : keep the current step
//   i_inc      : advance one step
//   o_sc       : current step value
//   o_t        : one-hot step decode; all zero for the illegal value 7
// ---------------------------------------------------------------------------
module bc_seq_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_inc,
   input  logic       i_hold,
   output logic [2:0] o_sc,
   output logic [6:0] o_t
);

   logic [2:0] r_sc;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sc <= 3'd0;
      end else if (i_clr) begin
         r_sc <= 3'd0;
      end else if (!i_hold && i_inc) begin
         r_sc <= r_sc + 3'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < 7; i++) begin
         o_t[i] = (r_sc == 3'(i));
      end
   end

   assign o_sc = r_sc;

endmodule

// File: rtl/bc_control_unit.sv
// ---------------------------------------------------------------------------
// bc_control_unit
// Hardwired control unit of the basic computer. Decodes the instruction
// register against the current timing step and emits the register-transfer
// controls that the datapath applies on the next rising clock edge.
//   clk, rst_n        : clock, async active-low reset
//   ir                : instruction register value
//   ac_n, ac_z, dr_z  : AC sign, AC zero, DR zero flags
//   e, start          : E flag, resume pulse after HLT
//   bus_sel           : common-bus source
//   alu_opsel         : ALU operation select
//   ar_ld .. e_alu_en : one-bit register controls (1 = active)
//   sc, halted        : current timing step, machine stopped
// ---------------------------------------------------------------------------
module bc_control_unit #(
   parameter int WIDTH = 16,
   parameter int AW    = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] ir,
   input  logic             ac_n,
   input  logic             ac_z,
   input  logic             dr_z,
   input  logic             e,
   input  logic             start,
   output logic [2:0]       bus_sel,
   output logic [2:0]       alu_opsel,
   output logic             ar_ld,
   output logic             ar_inc,
   output logic             pc_ld,
   output logic             pc_inc,
   output logic             dr_ld,
   output logic             dr_inc,
   output logic             ac_ld,
   output logic             ac_inc,
   output logic             ac_clr,
   output logic             ir_ld,
   output logic             tr_ld,
   output logic             mem_wr,
   output logic             e_clr,
   output logic             e_cmp,
   output logic             e_alu_en,
   output logic [2:0]       sc,
   output logic             halted
);

   import bc_pkg::*;

   logic          r_i_bit;
   logic          r_halted;
   logic [6:0]    w_t;
   logic          w_seq_clr;
   logic          w_seq_inc;
   logic          w_hlt;
   opcode_e       w_op;
   logic          w_d7;
   logic [AW-1:0] w_rr;
   logic          w_rr_onehot;
   ctl_t          w_ctl;
   ctl_t          w_out;

   assign w_op        = opcode_e'(ir[WIDTH-2 -: 3]);
   assign w_d7        = (w_op == OP_REG_IO);
   assign w_rr        = ir[AW-1:0];
   // Exactly one micro-op bit set; anything else is a NOP.
   assign w_rr_onehot = (w_rr != '0) && ((w_rr & (w_rr - 1'b1)) == '0);

   bc_seq_counter u_seq (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_seq_clr),
      .i_inc  (w_seq_inc),
      .i_hold (r_halted),
      .o_sc   (sc),
      .o_t    (w_t)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i_bit  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         if (w_t[2] && !r_halted) begin
            r_i_bit <= ir[WIDTH-1];
         end
         if (r_halted) begin
            if (start) begin
               r_halted <= 1'b0;
            end
         end else if (w_hlt) begin
            r_halted <= 1'b1;
         end
      end
   end

   // NOTE: every output of this block gets a default before any branch, so
   // no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_ctl     = CTL_IDLE;
      w_seq_clr = 1'b0;
      w_seq_inc = 1'b0;
      w_hlt     = 1'b0;
      if (r_halted) begin
         // Stopped: counter is held at T0 and all controls stay idle.
      end else if (w_t[0]) begin
         w_ctl.bus_sel = BUS_PC;
         w_ctl.ar_ld   = 1'b1;
         w_seq_inc     = 1'b1;
      end else if (w_t[1]) begin
         w_ctl.bus_sel = BUS_MEM;
         w_ctl.ir_ld   = 1'b1;
         w_ctl.pc_inc  = 1'b1;
         w_seq_inc     = 1'b1;
      end else if (w_t[2]) begin
         w_ctl.bus_sel = BUS_IR;
         w_ctl.ar_ld   = 1'b1;
         w_seq_inc     = 1'b1;
      end else if (w_t[3]) begin
         if (!w_d7) begin
            // Indirect memory reference fetches the effective address.
            if (r_i_bit) begin
               w_ctl.bus_sel = BUS_MEM;
               w_ctl.ar_ld   = 1'b1;
            end
            w_seq_inc = 1'b1;
         end else begin
            w_seq_clr = 1'b1;
            if (!r_i_bit && w_rr_onehot) begin
               if (w_rr[RR_CLA]) w_ctl.ac_clr = 1'b1;
               if (w_rr[RR_CLE]) w_ctl.e_clr  = 1'b1;
               if (w_rr[RR_CMA]) begin
                  w_ctl.ac_ld     = 1'b1;
                  w_ctl.alu_opsel = ALU_CMA;
               end
               if (w_rr[RR_CME]) w_ctl.e_cmp  = 1'b1;
               if (w_rr[RR_CIR]) begin
                  w_ctl.ac_ld     = 1'b1;
                  w_ctl.alu_opsel = ALU_CIR;
                  w_ctl.e_alu_en  = 1'b1;
               end
               if (w_rr[RR_CIL]) begin
                  w_ctl.ac_ld     = 1'b1;
                  w_ctl.alu_opsel = ALU_CIL;
                  w_ctl.e_alu_en  = 1'b1;
               end
               if (w_rr[RR_INC]) w_ctl.ac_inc = 1'b1;
               if (w_rr[RR_SPA]) w_ctl.pc_inc = !ac_n;
               if (w_rr[RR_SNA]) w_ctl.pc_inc = ac_n;
               if (w_rr[RR_SZA]) w_ctl.pc_inc = ac_z;
               if (w_rr[RR_SZE]) w_ctl.pc_inc = !e;
               if (w_rr[RR_HLT]) w_hlt        = 1'b1;
            end
         end
      end else if (w_t[4]) begin
         case (w_op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
               w_ctl.bus_sel = BUS_MEM;
               w_ctl.dr_ld   = 1'b1;
               w_seq_inc     = 1'b1;
            end
            OP_STA: begin
               w_ctl.bus_sel = BUS_AC;
               w_ctl.mem_wr  = 1'b1;
               w_seq_clr     = 1'b1;
            end
            OP_BUN: begin
               w_ctl.bus_sel = BUS_AR;
               w_ctl.pc_ld   = 1'b1;
               w_seq_clr     = 1'b1;
            end
            OP_BSA: begin
               w_ctl.bus_sel = BUS_PC;
               w_ctl.mem_wr  = 1'b1;
               w_ctl.ar_inc  = 1'b1;
               w_seq_inc     = 1'b1;
            end
            default: w_seq_clr = 1'b1;
         endcase
      end else if (w_t[5]) begin
         w_seq_clr = 1'b1;
         case (w_op)
            OP_AND: begin
               w_ctl.ac_ld     = 1'b1;
               w_ctl.alu_opsel = ALU_AND;
            end
            OP_ADD: begin
               w_ctl.ac_ld     = 1'b1;
               w_ctl.alu_opsel = ALU_ADD;
               w_ctl.e_alu_en  = 1'b1;
            end
            OP_LDA: w_ctl.ac_ld = 1'b1;
            OP_BSA: begin
               w_ctl.bus_sel = BUS_AR;
               w_ctl.pc_ld   = 1'b1;
            end
            OP_ISZ: begin
               w_ctl.dr_inc = 1'b1;
               w_seq_clr    = 1'b0;
               w_seq_inc    = 1'b1;
            end
            default: ;
         endcase
      end else if (w_t[6]) begin
         w_seq_clr = 1'b1;
         if (w_op == OP_ISZ) begin
            w_ctl.bus_sel = BUS_DR;
            w_ctl.mem_wr  = 1'b1;
            w_ctl.pc_inc  = dr_z;
         end
      end else begin
         // Illegal step 7: recover to T0 without issuing anything.
         w_seq_clr = 1'b1;
      end
   end

   // NOTE: reset also gates the outputs combinationally, so an in-flight
   // instruction cannot issue a write or load while rst_n is low.
   assign w_out = rst_n ? w_ctl : CTL_IDLE;

   assign bus_sel   = w_out.bus_sel;
   assign alu_opsel = w_out.alu_opsel;
   assign ar_ld     = w_out.ar_ld;
   assign ar_inc    = w_out.ar_inc;
   assign pc_ld     = w_out.pc_ld;
   assign pc_inc    = w_out.pc_inc;
   assign dr_ld     = w_out.dr_ld;
   assign dr_inc    = w_out.dr_inc;
   assign ac_ld     = w_out.ac_ld;
   assign ac_inc    = w_out.ac_inc;
   assign ac_clr    = w_out.ac_clr;
   assign ir_ld     = w_out.ir_ld;
   assign tr_ld     = w_out.tr_ld;
   assign mem_wr    = w_out.mem_wr;
   assign e_clr     = w_out.e_clr;
   assign e_cmp     = w_out.e_cmp;
   assign e_alu_en  = w_out.e_alu_en;
   assign halted    = r_halted;

endmodule

// File: tb/tb_bc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_bc_control_unit
// Self-checking bench. A per-instruction microprogram model turns each
// instruction into the list of control words it must produce, one per
// cycle; a compare process checks the DUT against that list on every
// cycle out of reset.
// ---------------------------------------------------------------------------
module tb_bc_control_unit;

   logic        clk;
   logic        rst_n;
   logic [15:0] ir;
   logic        ac_n, ac_z, dr_z, e, start;
   logic [2:0]  bus_sel, alu_opsel, sc;
   logic        ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ac_inc;
   logic        ac_clr, ir_ld, tr_ld, mem_wr, e_clr, e_cmp, e_alu_en, halted;

   bc_control_unit #(.WIDTH(16), .AW(12)) dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .ac_n(ac_n), .ac_z(ac_z),
      .dr_z(dr_z), .e(e), .start(start), .bus_sel(bus_sel),
      .alu_opsel(alu_opsel), .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld),
      .pc_inc(pc_inc), .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld),
      .ac_inc(ac_inc), .ac_clr(ac_clr), .ir_ld(ir_ld), .tr_ld(tr_ld),
      .mem_wr(mem_wr), .e_clr(e_clr), .e_cmp(e_cmp), .e_alu_en(e_alu_en),
      .sc(sc), .halted(halted)
   );

   // Control-bit masks for the model's control word.
   localparam int AR_LD  = 1 << 0;
   localparam int AR_INC = 1 << 1;
   localparam int PC_LD  = 1 << 2;
   localparam int PC_INC = 1 << 3;
   localparam int DR_LD  = 1 << 4;
   localparam int DR_INC = 1 << 5;
   localparam int AC_LD  = 1 << 6;
   localparam int AC_INC = 1 << 7;
   localparam int AC_CLR = 1 << 8;
   localparam int IR_LD  = 1 << 9;
   localparam int TR_LD  = 1 << 10;
   localparam int MEM_WR = 1 << 11;
   localparam int E_CLR  = 1 << 12;
   localparam int E_CMP  = 1 << 13;
   localparam int E_ALU  = 1 << 14;

   typedef struct {
      int sc;
      int bus;
      int op;
      int ctl;
      int hlt;
   } exp_t;

   exp_t        prog[$];
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] cur_ir;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input int s, input int b, input int o, input int c);
      exp_t x;
      x.sc = s; x.bus = b; x.op = o; x.ctl = c; x.hlt = 0;
      return x;
   endfunction

   // Microprogram model: the full sequence of control words for one
   // instruction given the flag values held during it.
   function automatic void build(input logic [15:0] instr, input bit an,
                                 input bit az, input bit dz, input bit ef);
      exp_t x;
      int   d;
      bit   ib;
      int   rr;
      prog.delete();
      d  = int'(instr[14:12]);
      ib = instr[15];
      rr = int'(instr[11:0]);
      prog.push_back(mk(0, 2, 2, AR_LD));
      prog.push_back(mk(1, 7, 2, IR_LD | PC_INC));
      prog.push_back(mk(2, 5, 2, AR_LD));
      if (d == 7) begin
         x = mk(3, 0, 2, 0);
         if (!ib && $countones(instr[11:0]) == 1) begin
            case (rr)
               'h800: x.ctl = AC_CLR;
               'h400: x.ctl = E_CLR;
               'h200: begin x.ctl = AC_LD; x.op = 3; end
               'h100: x.ctl = E_CMP;
               'h080: begin x.ctl = AC_LD | E_ALU; x.op = 4; end
               'h040: begin x.ctl = AC_LD | E_ALU; x.op = 5; end
               'h020: x.ctl = AC_INC;
               'h010: x.ctl = an ? 0 : PC_INC;
               'h008: x.ctl = an ? PC_INC : 0;
               'h004: x.ctl = az ? PC_INC : 0;
               'h002: x.ctl = ef ? 0 : PC_INC;
               default: x.ctl = 0;
            endcase
         end
         prog.push_back(x);
      end else begin
         prog.push_back(ib ? mk(3, 7, 2, AR_LD) : mk(3, 0, 2, 0));
         case (d)
            0: begin prog.push_back(mk(4, 7, 2, DR_LD)); prog.push_back(mk(5, 0, 1, AC_LD)); end
            1: begin prog.push_back(mk(4, 7, 2, DR_LD)); prog.push_back(mk(5, 0, 0, AC_LD | E_ALU)); end
            2: begin prog.push_back(mk(4, 7, 2, DR_LD)); prog.push_back(mk(5, 0, 2, AC_LD)); end
            3: prog.push_back(mk(4, 4, 2, MEM_WR));
            4: prog.push_back(mk(4, 1, 2, PC_LD));
            5: begin prog.push_back(mk(4, 2, 2, MEM_WR | AR_INC)); prog.push_back(mk(5, 1, 2, PC_LD)); end
            default: begin
               prog.push_back(mk(4, 7, 2, DR_LD));
               prog.push_back(mk(5, 0, 2, DR_INC));
               prog.push_back(mk(6, 3, 2, MEM_WR | (dz ? PC_INC : 0)));
            end
         endcase
      end
   endfunction

   function automatic int dut_ctl();
      return int'({e_alu_en, e_cmp, e_clr, mem_wr, tr_ld, ir_ld, ac_clr,
                   ac_inc, ac_ld, dr_inc, dr_ld, pc_inc, pc_ld, ar_inc, ar_ld});
   endfunction

   // Compare process: one expected word per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t x;
      if (rst_n && exp_q.size() != 0) begin
         x = exp_q.pop_front();
         check($sformatf("ir%h_T%0d_sc", cur_ir, x.sc), int'(sc), x.sc);
         check($sformatf("ir%h_T%0d_bus", cur_ir, x.sc), int'(bus_sel), x.bus);
         check($sformatf("ir%h_T%0d_opsel", cur_ir, x.sc), int'(alu_opsel), x.op);
         check($sformatf("ir%h_T%0d_ctl", cur_ir, x.sc), dut_ctl(), x.ctl);
         check($sformatf("ir%h_T%0d_halted", cur_ir, x.sc), int'(halted), x.hlt);
      end
   end

   // Drive one instruction starting in a T0 cycle; returns #2 after the edge
   // that ends it.
   task automatic run(input logic [15:0] instr, input bit an = 0, input bit az = 0,
                      input bit dz = 0, input bit ef = 0);
      check("queue_drained", exp_q.size(), 0);
      ir = instr; ac_n = an; ac_z = az; dr_z = dz; e = ef;
      cur_ir = instr;
      build(instr, an, az, dz, ef);
      foreach (prog[i]) exp_q.push_back(prog[i]);
      repeat (prog.size()) @(posedge clk);
      #2;
   endtask

   task automatic idle_halted(input int n);
      exp_t x;
      x = mk(0, 0, 2, 0);
      x.hlt = 1;
      for (int i = 0; i < n; i++) exp_q.push_back(x);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sc"}, int'(sc), 0);
      check({tag, "_bus"}, int'(bus_sel), 0);
      check({tag, "_opsel"}, int'(alu_opsel), 2);
      check({tag, "_ctl"}, dut_ctl(), 0);
      check({tag, "_halted"}, int'(halted), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; ir = 16'h7800; ac_n = 0; ac_z = 0; dr_z = 0; e = 0; start = 0;
      cur_ir = ir;

      // Pin the model with hand-derived words.
      build(16'h7800, 0, 0, 0, 0);
      check("pin_cla_len", prog.size(), 4);
      check("pin_cla_t3", prog[3].ctl, 'h100);
      build(16'h8010, 0, 0, 0, 0);
      check("pin_and_ind_len", prog.size(), 6);
      check("pin_and_ind_t3bus", prog[3].bus, 7);
      check("pin_and_ind_t5op", prog[5].op, 1);
      build(16'h1005, 0, 0, 0, 0);
      check("pin_add_t5ctl", prog[5].ctl, 'h4040);
      check("pin_add_t5op", prog[5].op, 0);
      build(16'h6020, 0, 0, 1, 0);
      check("pin_isz_len", prog.size(), 7);
      check("pin_isz_t6ctl", prog[6].ctl, 'h808);
      check("pin_isz_t6bus", prog[6].bus, 3);

      // Reset: outputs idle even though sc=0 would otherwise decode T0.
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
      #1 rst_n = 1'b1;

      run(16'h7800);                  // CLA
      run(16'h1005);                  // ADD direct
      run(16'h8010);                  // AND indirect
      run(16'h6020, 0, 0, 1, 0);      // ISZ, DR becomes zero
      run(16'h6020, 0, 0, 0, 0);      // ISZ, DR nonzero
      run(16'h7400);                  // CLE
      run(16'h7200);                  // CMA
      run(16'h7100);                  // CME
      run(16'h7080);                  // CIR
      run(16'h7040);                  // CIL
      run(16'h7020);                  // INC
      run(16'h7010, 0);               // SPA, AC positive: skip
      run(16'h7010, 1);               // SPA, AC negative: no skip
      run(16'h7008, 1);               // SNA, AC negative: skip
      run(16'h7004, 0, 0);            // SZA, AC nonzero: no skip
      run(16'h7004, 0, 1);            // SZA, AC zero: skip
      run(16'h7002, 0, 0, 0, 0);      // SZE, E clear: skip
      run(16'h7002, 0, 0, 0, 1);      // SZE, E set: no skip
      run(16'h7C00);                  // two bits set: NOP
      run(16'h7000);                  // no bits set: NOP
      run(16'hF800);                  // I/O: NOP
      run(16'h3ABC);                  // STA
      run(16'hCABC);                  // BUN indirect
      run(16'h5123);                  // BSA
      run(16'hA456);                  // LDA indirect

      // HLT, ten idle halted cycles, then a start pulse.
      run(16'h7001);
      idle_halted(10);
      start = 1'b1;
      idle_halted(1);
      start = 1'b0;
      run(16'h2123);                  // resumes at T0

      // Reset during T5 of ADD aborts the instruction immediately.
      check("queue_drained", exp_q.size(), 0);
      ir = 16'h1005; cur_ir = ir;
      build(ir, 0, 0, 0, 0);
      foreach (prog[i]) exp_q.push_back(prog[i]);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("abort_t5");
      @(posedge clk);
      #2 rst_n = 1'b1;
      run(16'h7800);                  // first cycle after release is T0

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bc_control_unit.md
BC_CONTROL_UNIT -- requirements
Module: bc_control_unit

Interface
REQ-001 Parameter: WIDTH, 16, datapath word width.
REQ-002 Parameter: AW, 12, address width; the operand address is IR[AW-1:0].
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset. Ports: clk in 1 system clock; rst_n in 1 async active-low reset.
REQ-004 Ports: ir in WIDTH instruction register value; ac_n in 1 AC[WIDTH-1]; ac_z in 1 AC==0; dr_z in 1 DR==0; e in 1 E flag; start in 1 resume pulse.
REQ-005 Ports: bus_sel out 3 common-bus source (0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory); alu_opsel out 3 ALU operation select.
REQ-006 Ports (out, 1 bit each, 1 = active): ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, mem_wr, e_clr, e_cmp, e_alu_en (permit ALU CNTRL_E to update E).
REQ-007 Ports: sc out 3 current timing step T0..T6; halted out 1 machine stopped.

Function
REQ-008 State SHALL be a 3-bit sequence counter sc plus flops i_bit and halted; all outputs are combinational from sc, i_bit, halted, ir and the flags; datapath registers act on the next rising clk edge.
REQ-009 Opcode decode: D = ir[14:12]; i_bit loads ir[15] at T2; D7 = (D==7).
REQ-010 T0: bus_sel=2, ar_ld. T1: bus_sel=7, ir_ld, pc_inc. T2: bus_sel=5, ar_ld, i_bit<=ir[15].
REQ-011 T3 with D7=0: if i_bit, bus_sel=7 and ar_ld; otherwise no control asserted. The step advances to T4 in both cases.
REQ-012 T3 with D7=1 and i_bit=0 (register reference): assert the action for the single set bit of ir[11:0], then set sc<=0. The actions are: b11 CLA ac_clr; b10 CLE e_clr; b9 CMA ac_ld, opsel 011; b8 CME e_cmp; b7 CIR ac_ld, opsel 100, e_alu_en; b6 CIL ac_ld, opsel 101, e_alu_en; b5 INC ac_inc; b4 SPA pc_inc if !ac_n; b3 SNA pc_inc if ac_n; b2 SZA pc_inc if ac_z; b1 SZE pc_inc if !e; b0 HLT halted<=1. Zero or multiple set bits SHALL act as a NOP.
REQ-013 T3 with D7=1 and i_bit=1 (I/O): NOP, then sc<=0.
REQ-014 AND: T4 bus 7, dr_ld; T5 ac_ld, opsel 001, sc<=0.
REQ-015 ADD: T4 bus 7, dr_ld; T5 ac_ld, opsel 000, e_alu_en, sc<=0.
REQ-016 LDA: T4 bus 7, dr_ld; T5 ac_ld, opsel 010, sc<=0.
REQ-017 STA: T4 bus 4, mem_wr, sc<=0.
REQ-018 BUN: T4 bus 1, pc_ld, sc<=0.
REQ-019 BSA: T4 bus 2, mem_wr, ar_inc; T5 bus 1, pc_ld, sc<=0.
REQ-020 ISZ: T4 bus 7, dr_ld; T5 dr_inc; T6 bus 3, mem_wr, pc_inc if dr_z, sc<=0.
REQ-021 alu_opsel SHALL be 010 whenever ac_ld is not asserted by an ALU operation; e_alu_en=0 except where listed above.
REQ-022 While halted=1, sc SHALL hold at 0 and all controls SHALL be 0. A start pulse clears halted on the next edge, and T0 begins on the following cycle.
REQ-023 sc SHALL never exceed 6. An unreachable sc value of 7 SHALL force sc<=0 with no controls asserted.

Reset
REQ-024 While rst_n=0: sc=0, i_bit=0, halted=0, and every control output is 0 (bus_sel=0, alu_opsel=010). The first rising edge after deassertion executes T0.
REQ-025 Reset asserted mid-instruction SHALL abort it immediately; no partial mem_wr or load is issued after assertion.

Structure
REQ-026 A shared package bc_pkg SHALL hold the opcode constants (AND..ISZ), the bus_sel encodings, the ALU opsel codes, and the register-reference bit indices.
REQ-027 One sub-module, bc_seq_counter, SHALL be used: 3-bit counter with clr, inc and hold inputs plus a one-hot T0..T6 decode.

Verification
REQ-028 Reset release, ir=0x7800 (CLA): T0..T3 then back to T0; ac_clr pulses only in T3; sc sequence 0,1,2,3,0.
REQ-029 ir=0x1005 (ADD direct): T3 idle; T4 bus_sel=7, dr_ld; T5 opsel=000, ac_ld, e_alu_en; then sc=0.
REQ-030 ir=0x8010 (AND indirect): T3 bus_sel=7, ar_ld; T5 opsel=001; total 6 cycles.
REQ-031 ir=0x6020 (ISZ) with dr_z=1 in T6: mem_wr=1, pc_inc=1. Repeat with dr_z=0: pc_inc=0.
REQ-032 ir=0x7001 (HLT): halted=1 and controls stay 0 for 10 cycles; start pulse resumes at T0 two edges later.
REQ-033 rst_n low during T5 of ADD: all outputs 0 immediately; the first cycle after release is T0.
